sensor_filter: RTL

Conditions the four raw obstacle/floor/barrier sensor lines before they reach the robot navigation state machine. Each line is synchronized into the `clock` domain and debounced, so it only changes after holding a new level for a programmable number of cycles. The block drives the navigation FSM's `head`, `left`, `under` and `barrier` inputs. It also provides a `valid` flag that the top level uses to hold the navigation FSM in reset (`robot_reset = reset | ~valid`) until the filtered sensor values are meaningful.

---
 rtl/sensor_filter.sv | 82 ++++++++
 1 files changed

// File: rtl/sensor_filter.sv
// Synchronizes and debounces the four raw robot sensor lines.
// Also produces a warm-up valid flag and a change pulse for the navigation FSM.
module sensor_filter #(
  parameter int DEBOUNCE  = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic head_raw,
  input  logic left_raw,
  input  logic under_raw,
  input  logic barrier_raw,
  output logic head,
  output logic left,
  output logic under,
  output logic barrier,
  output logic valid,
  output logic change
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(DEBOUNCE - 1);
  localparam logic [CNT_WIDTH-1:0] WARM_LAST = CNT_WIDTH'(DEBOUNCE + 1);

  typedef enum logic {WARMUP, RUN} state_t;

  state_t               state;
  logic [3:0]           raw;
  logic [3:0]           s1;
  logic [3:0]           s2;
  logic [3:0]           f;
  logic [3:0]           f_next;
  logic [CNT_WIDTH-1:0] cnt      [4];
  logic [CNT_WIDTH-1:0] cnt_next [4];
  logic [CNT_WIDTH-1:0] w;

  assign raw = {barrier_raw, under_raw, left_raw, head_raw};
  assign {barrier, under, left, head} = f;

  // A sample matching the filtered value clears the counter, so any bounce restarts qualification.
  always_comb begin
    f_next = f;
    for (int unsigned i = 0; i < 4; i++) begin
      cnt_next[i] = '0;
      if (s2[i] != f[i]) begin
        if (cnt[i] == CNT_LAST) f_next[i] = s2[i];
        else                    cnt_next[i] = cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1     <= '0;
      s2     <= '0;
      f      <= '0;
      cnt    <= '{default: '0};
      w      <= '0;
      state  <= WARMUP;
      valid  <= 1'b0;
      change <= 1'b0;
    end else begin
      s1     <= raw;
      s2     <= s1;
      f      <= f_next;
      cnt    <= cnt_next;
      // Uses the pre-edge valid, so startup transitions landing with valid's rise stay silent.
      change <= valid && (f_next != f);
      case (state)
        WARMUP: begin
          w <= w + 1'b1;
          if (w == WARM_LAST) begin
            state <= RUN;
            valid <= 1'b1;
          end
        end
        RUN: valid <= 1'b1;
        default: state <= WARMUP;
      endcase
    end
  end

endmodule
